vote_tally: RTL
===============

Name: vote_tally

Overview:
- Parametrised, sequential successor to the team's 5-voter/3-option majority voter.
- Collects one-hot ballots from N_VOTERS voters over a bounded voting window.
- Tallies each option, then scans the tallies sequentially to report a winner, the winning count, a majority flag and a tie flag.
- Sits between the voter front-ends and the decision/consumer logic; every result is registered, and there are no latches.

Parameters:
N_VOTERS, 5, number of voters (≥1)
N_OPTIONS, 3, number of options, one-hot ballot width (≥2)
TIMEOUT, 64, max COLLECT cycles before forced close (≥1)
CW (derived, localparam), $clog2(N_VOTERS+1), tally/count width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  open a voting round (accepted only in IDLE or DONE)
vote_valid  in  N_VOTERS  per-voter ballot strobe
vote_data  in  N_VOTERS*N_OPTIONS  ballots; voter i occupies bits [i*N_OPTIONS +: N_OPTIONS]
busy  out  1  high in COLLECT and DECIDE
done  out  1  one-cycle pulse when the result becomes valid
winner  out  N_OPTIONS  one-hot winning option; 0 if no valid votes
winner_count  out  CW  tally of the winning option
majority  out  1  winner_count > N_VOTERS/2 (integer division)
tie  out  1  another option equals the winning tally (count > 0)
voted_mask  out  N_VOTERS  voters whose strobe was accepted this round
invalid_mask  out  N_VOTERS  accepted voters whose ballot was not one-hot
timed_out  out  1  round closed by TIMEOUT, not by full turnout

Behaviour:
- Reset (synchronous; wins over everything, including mid-round): state = IDLE, and all outputs, tallies and timer are 0.
- FSM states: IDLE, COLLECT, DECIDE, DONE.
- IDLE/DONE, start=1 → COLLECT next cycle:
  - clear tallies, voted_mask, invalid_mask, timer and timed_out;
  - result outputs (winner, winner_count, majority, tie) keep their old values until the next done.
- start is ignored in COLLECT and DECIDE.
- Ballot acceptance in COLLECT, for each voter i:
  - accepted when vote_valid[i]=1 and voted_mask[i]=0;
  - accepting sets voted_mask[i]; later strobes from that voter are ignored (one vote per voter per round);
  - one-hot ballot: increments the tally of that option;
  - zero or multi-hot ballot: sets invalid_mask[i] and counts as an abstention (no tally change).
- Several voters may be accepted in the same cycle. The tally increment is a popcount across voters, per option.
- Tallies saturate at N_VOTERS by construction, so there is no wrap.
- Timer: increments every COLLECT cycle.
- COLLECT → DECIDE when either:
  - voted_mask becomes all-ones, including ballots accepted in that same cycle; or
  - timer reaches TIMEOUT-1 (set timed_out=1). Ballots presented on that final cycle are still accepted.
  - If both occur in the same cycle, timed_out=0.
- DECIDE: sequential scan of option 0 up to N_OPTIONS-1, one option per cycle (N_OPTIONS cycles). Running best = strictly greater tally, so on equal tallies the lowest index wins.
  - tie is set if a later option equals the running best and the best is > 0;
  - tie is cleared when a strictly greater tally replaces the best.
- DECIDE → DONE after the last option:
  - register winner (one-hot), winner_count, majority and tie;
  - done=1 for exactly this one cycle.
- Zero valid votes: winner=0, winner_count=0, majority=0, tie=0.
- DONE: outputs hold; it waits for start.
- Latency:
  - full turnout in cycle k of COLLECT → done at cycle k+N_OPTIONS+1;
  - timeout → done TIMEOUT+N_OPTIONS cycles after COLLECT entry.
- busy=1 in COLLECT and DECIDE; otherwise 0.

Decomposition:
- Package vote_pkg holds:
  - state enum (IDLE, COLLECT, DECIDE, DONE);
  - function is_onehot(vector);
  - function onehot_of(index, width).
- Sub-module vote_popcount: popcount over N_VOTERS one-bit inputs, CW-bit output. Instantiated once per option to form the tally increments.
- FSM, timer and decision scan live in vote_tally.

Test Plan:
- Defaults, start; cycle 1 voters 0-4 strobe 001,001,001,010,100 → done 4 cycles later; winner=001, count=3, majority=1, tie=0, timed_out=0.
- Voters 0,1 strobe 010; voters 2,3 strobe 100; voter 4 strobe 000 → winner=010, count=2, tie=1, majority=0, invalid_mask=10000.
- Voter 0 strobes 001 twice, then 100; others silent until TIMEOUT → winner=001, count=1, voted_mask=00001, timed_out=1, done at TIMEOUT+3 cycles.
- No strobes for a whole round → winner=000, count=0, tie=0, majority=0, timed_out=1.
- rst asserted mid-COLLECT after 3 votes → next cycle IDLE, all outputs 0. A new start with fresh votes yields results free of the earlier votes.
- N_VOTERS=7, N_OPTIONS=4: all 7 vote 1000 in one cycle, with start pulsed during DECIDE → start ignored; winner=1000, count=7, majority=1, done 5 cycles after the vote cycle.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote_tally block.
// Helpers operate on 64-bit vectors so one definition serves every parameterisation.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

  function automatic logic [63:0] onehot_of(input int unsigned index, input int unsigned width);
    logic [63:0] r;
    r = 64'd0;
    if (index < width && index < 64) r = 64'd1 << index;
    return r;
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Counts the set bits of an N-bit vector; one instance per option forms the tally increment.
module vote_popcount #(
  parameter int N = 5,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/vote_tally.sv
// Collects one-hot ballots over a bounded window, then scans the per-option tallies
// one option per cycle to report winner, count, majority and tie.
module vote_tally
  import vote_pkg::*;
#(
  parameter int N_VOTERS  = 5,
  parameter int N_OPTIONS = 3,
  parameter int TIMEOUT   = 64,
  localparam int CW = $clog2(N_VOTERS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_VOTERS-1:0]           vote_valid,
  input  logic [N_VOTERS*N_OPTIONS-1:0] vote_data,
  output logic                          busy,
  output logic                          done,
  output logic [N_OPTIONS-1:0]          winner,
  output logic [CW-1:0]                 winner_count,
  output logic                          majority,
  output logic                          tie,
  output logic [N_VOTERS-1:0]           voted_mask,
  output logic [N_VOTERS-1:0]           invalid_mask,
  output logic                          timed_out
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(N_OPTIONS);
  localparam logic [CW-1:0] HALF = CW'(N_VOTERS / 2);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_DECIDE  = DECIDE;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]           state_reg;
  logic [TW-1:0]        timer_reg;
  logic [SW-1:0]        scan_reg;
  logic [CW-1:0]        tally_reg [N_OPTIONS];
  logic [CW-1:0]        best_cnt_reg;
  logic [SW-1:0]        best_idx_reg;
  logic                 tie_scan_reg;
  logic [N_VOTERS-1:0]  voted_reg;
  logic [N_VOTERS-1:0]  invalid_reg;
  logic                 timed_out_reg;
  logic                 done_reg;
  logic [N_OPTIONS-1:0] winner_reg;
  logic [CW-1:0]        winner_count_reg;
  logic                 majority_reg;
  logic                 tie_reg;

  logic [N_VOTERS-1:0]                 accept;
  logic [N_VOTERS-1:0]                 ballot_ok;
  logic [N_OPTIONS-1:0][N_VOTERS-1:0]  hit;
  logic [CW-1:0]                       inc [N_OPTIONS];

  genvar gi, gv;
  generate
    for (gv = 0; gv < N_VOTERS; gv++) begin : g_voter
      assign accept[gv]    = vote_valid[gv] & ~voted_reg[gv];
      assign ballot_ok[gv] = accept[gv] & is_onehot(64'(vote_data[gv*N_OPTIONS +: N_OPTIONS]));
    end
    for (gi = 0; gi < N_OPTIONS; gi++) begin : g_option
      for (gv = 0; gv < N_VOTERS; gv++) begin : g_hit
        assign hit[gi][gv] = ballot_ok[gv] & vote_data[gv*N_OPTIONS + gi];
      end
      vote_popcount #(.N(N_VOTERS)) u_popcount (
        .bits  (hit[gi]),
        .count (inc[gi])
      );
    end
  endgenerate

  logic [N_VOTERS-1:0]  voted_next;
  logic                 all_in, at_limit, last_opt;
  logic [CW-1:0]        cur_tally, best_cnt_next;
  logic [SW-1:0]        best_idx_next;
  logic                 tie_next;
  logic [N_OPTIONS-1:0] winner_next;

  always_comb begin
    voted_next    = voted_reg | vote_valid;
    all_in        = &voted_next;
    at_limit      = (timer_reg == TW'(TIMEOUT - 1));
    last_opt      = (scan_reg == SW'(N_OPTIONS - 1));
    cur_tally     = tally_reg[scan_reg];
    best_cnt_next = best_cnt_reg;
    best_idx_next = best_idx_reg;
    tie_next      = tie_scan_reg;
    // Strictly-greater replacement keeps the lowest index on equal tallies.
    if (cur_tally > best_cnt_reg) begin
      best_cnt_next = cur_tally;
      best_idx_next = scan_reg;
      tie_next      = 1'b0;
    end else if (cur_tally == best_cnt_reg && best_cnt_reg != '0) begin
      tie_next = 1'b1;
    end
    winner_next = (best_cnt_next == '0) ? '0
                : N_OPTIONS'(onehot_of(32'(best_idx_next), N_OPTIONS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      timer_reg        <= '0;
      scan_reg         <= '0;
      for (int j = 0; j < N_OPTIONS; j++) tally_reg[j] <= '0;
      best_cnt_reg     <= '0;
      best_idx_reg     <= '0;
      tie_scan_reg     <= 1'b0;
      voted_reg        <= '0;
      invalid_reg      <= '0;
      timed_out_reg    <= 1'b0;
      done_reg         <= 1'b0;
      winner_reg       <= '0;
      winner_count_reg <= '0;
      majority_reg     <= 1'b0;
      tie_reg          <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg     <= ST_COLLECT;
            timer_reg     <= '0;
            for (int j = 0; j < N_OPTIONS; j++) tally_reg[j] <= '0;
            voted_reg     <= '0;
            invalid_reg   <= '0;
            timed_out_reg <= 1'b0;
          end
        end
        ST_COLLECT: begin
          timer_reg   <= timer_reg + TW'(1);
          voted_reg   <= voted_next;
          invalid_reg <= invalid_reg | (accept & ~ballot_ok);
          for (int j = 0; j < N_OPTIONS; j++) tally_reg[j] <= tally_reg[j] + inc[j];
          if (all_in || at_limit) begin
            state_reg     <= ST_DECIDE;
            timed_out_reg <= at_limit & ~all_in;
            scan_reg      <= '0;
            best_cnt_reg  <= '0;
            best_idx_reg  <= '0;
            tie_scan_reg  <= 1'b0;
          end
        end
        ST_DECIDE: begin
          scan_reg     <= scan_reg + SW'(1);
          best_cnt_reg <= best_cnt_next;
          best_idx_reg <= best_idx_next;
          tie_scan_reg <= tie_next;
          if (last_opt) begin
            state_reg        <= ST_DONE;
            done_reg         <= 1'b1;
            winner_reg       <= winner_next;
            winner_count_reg <= best_cnt_next;
            majority_reg     <= (best_cnt_next > HALF);
            tie_reg          <= tie_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state_reg == ST_COLLECT) || (state_reg == ST_DECIDE);
  assign done         = done_reg;
  assign winner       = winner_reg;
  assign winner_count = winner_count_reg;
  assign majority     = majority_reg;
  assign tie          = tie_reg;
  assign voted_mask   = voted_reg;
  assign invalid_mask = invalid_reg;
  assign timed_out    = timed_out_reg;

endmodule
